// File: rtl/vec_lane_exec.sv
// Lane-wise vector execute unit: six 8-bit lanes, single-cycle ALU ops and a
// lane-serial six-cycle multiply, writing back through a one-cycle we3 strobe.
module vec_lane_exec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [47:0] src_a,
    input  logic [47:0] src_b,
    input  logic [3:0]  dest,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        we3,
    output logic [3:0]  ra3,
    output logic [47:0] wd3
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpMul = 3'b101;
    localparam logic [2:0] OpShl = 3'b110;

    typedef enum logic [1:0] {StIdle, StMul, StWb} state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [47:0] a_q;
    logic [47:0] b_q;
    logic [47:0] result_q;
    logic [3:0]  dest_q;

    logic [47:0] alu_res;
    logic [47:0] mul_res;
    logic [5:0]  lane_lsb;
    logic [7:0]  prod;
    logic        req_bad;

    assign busy    = (state_q != StIdle);
    assign req_bad = (op == 3'b111) || (dest > 4'd13);

    always_comb begin
        alu_res = 48'h0;
        for (int i = 0; i < 6; i++) begin
            case (op)
                OpAdd:   alu_res[8*i +: 8] = src_a[8*i +: 8] + src_b[8*i +: 8];
                OpSub:   alu_res[8*i +: 8] = src_a[8*i +: 8] - src_b[8*i +: 8];
                OpAnd:   alu_res[8*i +: 8] = src_a[8*i +: 8] & src_b[8*i +: 8];
                OpOr:    alu_res[8*i +: 8] = src_a[8*i +: 8] | src_b[8*i +: 8];
                OpXor:   alu_res[8*i +: 8] = src_a[8*i +: 8] ^ src_b[8*i +: 8];
                OpShl:   alu_res[8*i +: 8] = src_a[8*i +: 8] << src_b[8*i +: 3];
                default: alu_res[8*i +: 8] = 8'h00;
            endcase
        end
    end

    // 8-bit operands in an 8-bit context keep only the low byte of the product.
    always_comb begin
        lane_lsb = {cnt_q, 3'b000};
        prod     = a_q[lane_lsb +: 8] * b_q[lane_lsb +: 8];
        mul_res  = result_q;
        mul_res[lane_lsb +: 8] = prod;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            a_q      <= 48'h0;
            b_q      <= 48'h0;
            result_q <= 48'h0;
            dest_q   <= 4'd0;
            done     <= 1'b0;
            err      <= 1'b0;
            we3      <= 1'b0;
            ra3      <= 4'd0;
            wd3      <= 48'h0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            we3  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (req_bad) begin
                            err <= 1'b1;
                        end else if (op == OpMul) begin
                            a_q     <= src_a;
                            b_q     <= src_b;
                            dest_q  <= dest;
                            cnt_q   <= 3'd0;
                            state_q <= StMul;
                        end else begin
                            // Write-back outputs are loaded here so they are live during WB.
                            result_q <= alu_res;
                            dest_q   <= dest;
                            we3      <= 1'b1;
                            done     <= 1'b1;
                            ra3      <= dest;
                            wd3      <= alu_res;
                            state_q  <= StWb;
                        end
                    end
                end
                StMul: begin
                    result_q <= mul_res;
                    if (cnt_q == 3'd5) begin
                        cnt_q   <= 3'd0;
                        we3     <= 1'b1;
                        done    <= 1'b1;
                        ra3     <= dest_q;
                        wd3     <= mul_res;
                        state_q <= StWb;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StWb:    state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
